etc_pixel_addr_walker: RTL and testbench

Parametrised destination-address walker for the ETC2 decoder write path. Accepts one block command (block coordinates, surface base, pitch, surface dimensions) and emits, one per cycle under valid/ready flow control, the byte address of every in-surface pixel of that 4x4 block in ETC pixel-index order. Right- and bottom-edge blocks are clipped. Supports a configurable pixel size. Sits between the block scheduler and the pixel write-out stage.

---
 rtl/etc_addr_pkg.sv | 16 +
 rtl/etc_blk_clip.sv | 54 +++++
 rtl/etc_pixel_addr_walker.sv | 192 +++++++++++++++++++
 tb/tb_etc_pixel_addr_walker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/etc_addr_pkg.sv
// Shared definitions for the ETC2 pixel address walker.
package etc_addr_pkg;

  // ETC blocks are 4x4 pixels.
  localparam int unsigned BLK_DIM      = 4;
  localparam int unsigned BLK_DIM_LOG2 = 2;
  localparam int unsigned BLK_PIX      = 16;

  // Walker control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } walk_state_e;

endpackage

// File: rtl/etc_blk_clip.sv
// Block clip: number of in-surface columns/rows (0..4) of a 4x4 block.
// Purely combinational so the decoder write mask can share it.
module etc_blk_clip
  import etc_addr_pkg::*;
#(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned DIM_W   = 11
) (
  input  logic [DIM_W-1:0]   i_width,
  input  logic [DIM_W-1:0]   i_height,
  input  logic [COORD_W-1:0] i_blk_x,
  input  logic [COORD_W-1:0] i_blk_y,
  output logic [2:0]         o_cols,
  output logic [2:0]         o_rows
);

  // Signed working width: wide enough for dimension and 4*coordinate.
  localparam int unsigned SW = ((DIM_W > COORD_W + 2) ? DIM_W : COORD_W + 2) + 2;

  logic [SW-1:0]        w_span_x;
  logic [SW-1:0]        w_span_y;
  logic signed [SW-1:0] w_rem_x;
  logic signed [SW-1:0] w_rem_y;

  assign w_span_x = SW'({i_blk_x, 2'b00});
  assign w_span_y = SW'({i_blk_y, 2'b00});
  assign w_rem_x  = $signed(SW'(i_width))  - $signed(w_span_x);
  assign w_rem_y  = $signed(SW'(i_height)) - $signed(w_span_y);

  // Clamp remaining columns to 0..BLK_DIM.
  always_comb begin
    o_cols = '0;
    if (w_rem_x[SW-1] || (w_rem_x == '0)) begin
      o_cols = '0;
    end else if (w_rem_x >= SW'(BLK_DIM)) begin
      o_cols = 3'(BLK_DIM);
    end else begin
      o_cols = w_rem_x[2:0];
    end
  end

  // Clamp remaining rows to 0..BLK_DIM.
  always_comb begin
    o_rows = '0;
    if (w_rem_y[SW-1] || (w_rem_y == '0)) begin
      o_rows = '0;
    end else if (w_rem_y >= SW'(BLK_DIM)) begin
      o_rows = 3'(BLK_DIM);
    end else begin
      o_rows = w_rem_y[2:0];
    end
  end

endmodule

// File: rtl/etc_pixel_addr_walker.sv
// ETC2 write-path address walker: turns one block command into the byte
// addresses of its in-surface pixels, column-major, one per handshake.
module etc_pixel_addr_walker
  import etc_addr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned DIM_W    = 11,
  parameter int unsigned PITCH_W  = 16,
  parameter int unsigned BPP_LOG2 = 2
) (
  input  logic               sclk,
  input  logic               rsrt,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] blk_x,
  input  logic [COORD_W-1:0] blk_y,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [PITCH_W-1:0] pitch,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [3:0]         out_pix_idx,
  output logic               out_last,
  output logic               blk_done,
  output logic               blk_empty
);

  walk_state_e r_state;
  walk_state_e w_state_nxt;

  logic [COORD_W-1:0] r_blk_x;
  logic [COORD_W-1:0] r_blk_y;
  logic [ADDR_W-1:0]  r_base;
  logic [PITCH_W-1:0] r_pitch;
  logic [DIM_W-1:0]   r_width;
  logic [DIM_W-1:0]   r_height;
  logic [2:0]         r_cols;
  logic [2:0]         r_rows;
  logic [1:0]         r_x;
  logic [1:0]         r_y;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_col_base;
  logic               r_done;
  logic               r_empty;

  logic [2:0]         w_cols;
  logic [2:0]         w_rows;
  logic               w_blk_empty;
  logic               w_accept;
  logic               w_hs;
  logic               w_col_end;
  logic               w_last;
  logic [ADDR_W-1:0]  w_yoff;
  logic [ADDR_W-1:0]  w_xoff;
  logic [ADDR_W-1:0]  w_row_base;
  logic [ADDR_W-1:0]  w_pix_step;
  logic [ADDR_W-1:0]  w_pitch_ext;

  etc_blk_clip #(
    .COORD_W (COORD_W),
    .DIM_W   (DIM_W)
  ) u_clip (
    .i_width  (r_width),
    .i_height (r_height),
    .i_blk_x  (r_blk_x),
    .i_blk_y  (r_blk_y),
    .o_cols   (w_cols),
    .o_rows   (w_rows)
  );

  assign w_blk_empty = (w_cols == '0) || (w_rows == '0);

  // Address arithmetic wraps modulo 2^ADDR_W; the only multiplier is blk_y*pitch.
  assign w_pitch_ext = ADDR_W'(r_pitch);
  assign w_yoff      = ADDR_W'(r_blk_y) * w_pitch_ext;
  assign w_xoff      = ADDR_W'({r_blk_x, 2'b00}) << BPP_LOG2;
  assign w_row_base  = r_base + (w_yoff << BLK_DIM_LOG2) + w_xoff;
  assign w_pix_step  = ADDR_W'(1) << BPP_LOG2;

  assign w_col_end = ({1'b0, r_y} == (r_rows - 3'd1));
  assign w_last    = w_col_end && ({1'b0, r_x} == (r_cols - 3'd1));

  // State register.
  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake-derived outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_hs        = 1'b0;
    cmd_ready   = 1'b0;
    addr_valid  = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = !rsrt;
        w_accept  = cmd_valid && !rsrt;
        if (w_accept) begin
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_state_nxt = w_blk_empty ? IDLE : RUN;
      end
      RUN: begin
        addr_valid = 1'b1;
        out_last   = w_last;
        w_hs       = addr_ready;
        if (w_hs && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Command latch, setup load and per-handshake address stepping.
  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      r_blk_x    <= '0;
      r_blk_y    <= '0;
      r_base     <= '0;
      r_pitch    <= '0;
      r_width    <= '0;
      r_height   <= '0;
      r_cols     <= '0;
      r_rows     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_col_base <= '0;
      r_done     <= 1'b0;
      r_empty    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_empty <= 1'b0;
      if (w_accept) begin
        r_blk_x  <= blk_x;
        r_blk_y  <= blk_y;
        r_base   <= base_addr;
        r_pitch  <= pitch;
        r_width  <= width;
        r_height <= height;
      end
      if (r_state == SETUP) begin
        r_cols <= w_cols;
        r_rows <= w_rows;
        r_x    <= '0;
        r_y    <= '0;
        if (w_blk_empty) begin
          r_done  <= 1'b1;
          r_empty <= 1'b1;
        end else begin
          r_addr     <= w_row_base;
          r_col_base <= w_row_base;
        end
      end
      // Column base is kept separately so a column step never has to
      // subtract (rows-1)*pitch back out of the running address.
      if (w_hs) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else if (w_col_end) begin
          r_x        <= r_x + 2'd1;
          r_y        <= '0;
          r_addr     <= r_col_base + w_pix_step;
          r_col_base <= r_col_base + w_pix_step;
        end else begin
          r_y    <= r_y + 2'd1;
          r_addr <= r_addr + w_pitch_ext;
        end
      end
    end
  end

  assign out_addr    = r_addr;
  assign out_pix_idx = {r_x, r_y};
  assign blk_done    = r_done;
  assign blk_empty   = r_empty;

endmodule

// File: tb/tb_etc_pixel_addr_walker.sv
// Directed self-checking bench for etc_pixel_addr_walker.
module tb_etc_pixel_addr_walker;

  localparam int BPP = 2;

  logic        sclk;
  logic        rsrt;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  blk_x;
  logic [7:0]  blk_y;
  logic [31:0] base_addr;
  logic [15:0] pitch;
  logic [10:0] width;
  logic [10:0] height;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] out_addr;
  logic [3:0]  out_pix_idx;
  logic        out_last;
  logic        blk_done;
  logic        blk_empty;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  etc_pixel_addr_walker #(
    .ADDR_W   (32),
    .COORD_W  (8),
    .DIM_W    (11),
    .PITCH_W  (16),
    .BPP_LOG2 (BPP)
  ) dut (
    .sclk        (sclk),
    .rsrt        (rsrt),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .base_addr   (base_addr),
    .pitch       (pitch),
    .width       (width),
    .height      (height),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .out_addr    (out_addr),
    .out_pix_idx (out_pix_idx),
    .out_last    (out_last),
    .blk_done    (blk_done),
    .blk_empty   (blk_empty)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] base, input logic [15:0] pit,
                       input logic [7:0] bx, input logic [7:0] by,
                       input logic [10:0] w, input logic [10:0] h,
                       output int t_acc);
    @(negedge sclk);
    blk_x     = bx;
    blk_y     = by;
    base_addr = base;
    pitch     = pit;
    width     = w;
    height    = h;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    t_acc = cyc;
    @(posedge sclk);
    #1 cmd_valid = 1'b0;
  endtask

  // Walks one non-empty block; expected address from the direct formula
  // base + 4*by*pitch + (4*bx << BPP) + (x << BPP) + y*pitch.
  task automatic walk(input logic [31:0] base, input logic [15:0] pit,
                      input logic [7:0] bx, input logic [7:0] by,
                      input logic [10:0] w, input logic [10:0] h,
                      input int ncols, input int nrows,
                      input logic [31:0] rdy_pat, input int abort_after,
                      output int t_acc, output int t_done);
    int i;
    int x;
    int y;
    int step;
    logic [31:0] exp;
    issue(base, pit, bx, by, w, h, t_acc);
    @(negedge sclk);
    chk("setup_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("setup_valid", 64'(addr_valid), 64'd0);
    i = 0;
    step = 0;
    t_done = -1;
    while (i < ncols * nrows && step < 200) begin
      @(negedge sclk);
      x = i / nrows;
      y = i % nrows;
      exp = base + ((32'(by) * 32'(pit)) << 2) + (32'(bx) << (2 + BPP))
            + (32'(x) << BPP) + 32'(y) * 32'(pit);
      chk("valid", 64'(addr_valid), 64'd1);
      chk("addr", 64'(out_addr), 64'(exp));
      chk("pix_idx", 64'(out_pix_idx), 64'(x * 4 + y));
      chk("last", 64'(out_last), 64'(i == ncols * nrows - 1));
      chk("done_in_run", 64'(blk_done), 64'd0);
      chk("run_cmd_ready", 64'(cmd_ready), 64'd0);
      addr_ready = rdy_pat[step % 32];
      step++;
      @(posedge sclk);
      if (addr_ready) i++;
      if (abort_after > 0 && i == abort_after) break;
    end
    chk("walk_budget", 64'(step < 200), 64'd1);
    if (abort_after > 0) return;
    @(negedge sclk);
    chk("blk_done", 64'(blk_done), 64'd1);
    chk("blk_empty_full", 64'(blk_empty), 64'd0);
    chk("valid_after", 64'(addr_valid), 64'd0);
    chk("cmd_ready_done", 64'(cmd_ready), 64'd1);
    t_done = cyc;
    addr_ready = 1'b1;
  endtask

  int t_acc;
  int t_done;

  initial begin
    rsrt       = 1'b1;
    cmd_valid  = 1'b0;
    addr_ready = 1'b1;
    blk_x      = '0;
    blk_y      = '0;
    base_addr  = '0;
    pitch      = '0;
    width      = '0;
    height     = '0;

    // Reset state.
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_valid", 64'(addr_valid), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    chk("rst_idx", 64'(out_pix_idx), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_done", 64'(blk_done), 64'd0);
    chk("rst_empty", 64'(blk_empty), 64'd0);
    repeat (2) @(negedge sclk);
    rsrt = 1'b0;
    #1 chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Full block (1,2): 0x1810,0x1910,0x1A10,0x1B10,0x1814,...,0x1B1C; done at T+18.
    walk(32'h0000_1000, 16'd256, 8'd1, 8'd2, 11'd64, 11'd64, 4, 4,
         32'hFFFF_FFFF, 0, t_acc, t_done);
    chk("full_done_latency", 64'(t_done - t_acc), 64'd18);

    // Edge block (1,1) on 6x5: cols=2 rows=1, base+112 then base+116.
    walk(32'h0004_0000, 16'd24, 8'd1, 8'd1, 11'd6, 11'd5, 2, 1,
         32'hFFFF_FFFF, 0, t_acc, t_done);
    chk("edge_done_latency", 64'(t_done - t_acc), 64'd4);

    // Fully outside block (3,0) with width 8: no addresses, done+empty at T+2.
    issue(32'h0000_2000, 16'd32, 8'd3, 8'd0, 11'd8, 11'd8, t_acc);
    @(negedge sclk);
    chk("empty_setup_valid", 64'(addr_valid), 64'd0);
    chk("empty_setup_done", 64'(blk_done), 64'd0);
    @(negedge sclk);
    chk("empty_at_T2", 64'(cyc - t_acc), 64'd2);
    chk("empty_done", 64'(blk_done), 64'd1);
    chk("empty_flag", 64'(blk_empty), 64'd1);
    chk("empty_valid", 64'(addr_valid), 64'd0);
    chk("empty_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge sclk);
    chk("empty_done_pulse", 64'(blk_done), 64'd0);

    // Stalled full block: held outputs, 16 in-order handshakes.
    walk(32'h0000_2000, 16'd64, 8'd0, 8'd0, 11'd64, 11'd64, 4, 4,
         32'b1011_0110_1101_0011_1001_1010_1110_0101, 0, t_acc, t_done);

    // Wrap: base 0xFFFF_FFF0 -> 0xFFFF_FFF0, 0x0000_00F0, 0x0000_01F0, ...
    walk(32'hFFFF_FFF0, 16'd256, 8'd0, 8'd0, 11'd64, 11'd64, 4, 4,
         32'hFFFF_FFFF, 0, t_acc, t_done);

    // Reset after the 5th handshake.
    walk(32'h0000_4000, 16'd128, 8'd2, 8'd2, 11'd64, 11'd64, 4, 4,
         32'hFFFF_FFFF, 5, t_acc, t_done);
    @(negedge sclk);
    rsrt = 1'b1;
    #1;
    chk("abort_valid", 64'(addr_valid), 64'd0);
    chk("abort_addr", 64'(out_addr), 64'd0);
    chk("abort_idx", 64'(out_pix_idx), 64'd0);
    chk("abort_last", 64'(out_last), 64'd0);
    chk("abort_done", 64'(blk_done), 64'd0);
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge sclk);
    chk("abort_done_later", 64'(blk_done), 64'd0);
    rsrt = 1'b0;
    walk(32'h0000_8000, 16'd32, 8'd0, 8'd0, 11'd64, 11'd64, 4, 4,
         32'hFFFF_FFFF, 0, t_acc, t_done);
    chk("post_reset_latency", 64'(t_done - t_acc), 64'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
